core_boot_loader: RTL and testbench

//  Byte-stream boot sequencer for the core. It decodes host command frames, drives the core's

---
 rtl/core_boot_loader.sv | 209 ++++++++++++++++++++
 tb/tb_core_boot_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_boot_loader.sv
// rtl/core_boot_loader.sv - host byte-stream boot sequencer driving core insn/data back-door writes and run level
// Optional trailing checksum byte on write frames: CORE_BOOT_LOADER_CKSUM_EN
module core_boot_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      insn_addr,
   output logic [31:0]      insn_din,
   output logic             insn_we,
   output logic [31:0]      data_addr,
   output logic [31:0]      data_din,
   output logic             data_we,
   output logic             run,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] write_count
);

   localparam logic [7:0] CMD_INSN = 8'h01;
   localparam logic [7:0] CMD_DATA = 8'h02;
   localparam logic [7:0] CMD_RUN  = 8'h03;
   localparam logic [7:0] CMD_HALT = 8'h04;
   localparam logic [7:0] CMD_CLR  = 8'h05;

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_CMD  = 3'd1;
   localparam logic [2:0] ERR_RUN  = 3'd2;
   localparam logic [2:0] ERR_TO   = 3'd3;

`ifdef CORE_BOOT_LOADER_CKSUM_EN
   localparam logic [2:0] ERR_CSUM = 3'd4;
   typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_CSUM, S_WRITE} state_t;
`else
   typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_WRITE} state_t;
`endif

   state_t      state, state_nxt;
   logic [1:0]  byte_cnt;
   logic        is_insn;
   logic [31:0] addr_sh;
   logic [31:0] data_sh;
   logic [31:0] data_merge;
   logic [31:0] timer;
   logic        accept;
   logic        in_frame;
   logic        timed_out;
   logic        frame_end;
   logic        load_out;
   logic        run_nxt;
   logic [2:0]  err_nxt;
`ifdef CORE_BOOT_LOADER_CKSUM_EN
   logic [7:0]  csum;
   logic [7:0]  csum_nxt;

   assign csum_nxt = csum + in_data;
   assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
`else
   assign in_frame = (state == S_ADDR) || (state == S_DATA);
`endif

   assign in_ready  = reset && (state != S_WRITE);
   assign accept    = in_valid && in_ready;
   assign timed_out = (TIMEOUT_CYCLES != 0) && in_frame && !accept &&
                      (timer == 32'(TIMEOUT_CYCLES - 1));
   assign insn_we   = (state == S_WRITE) && is_insn;
   assign data_we   = (state == S_WRITE) && !is_insn;

   // Data word with the byte being accepted this cycle already merged in.
   always_comb begin
      data_merge = data_sh;
      if (state == S_DATA && accept)
         data_merge[{byte_cnt, 3'b000} +: 8] = in_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_CMD;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      err_nxt   = err_code;
      frame_end = 1'b0;
      load_out  = 1'b0;
      case (state)
         S_CMD: begin
            if (accept) begin
               case (in_data)
                  CMD_INSN, CMD_DATA: state_nxt = S_ADDR;
                  CMD_RUN:            run_nxt   = 1'b1;
                  CMD_HALT:           run_nxt   = 1'b0;
                  CMD_CLR:            err_nxt   = ERR_NONE;
                  default:            err_nxt   = ERR_CMD;
               endcase
            end
         end
         S_ADDR: begin
            if (accept && byte_cnt == 2'd3)
               state_nxt = S_DATA;
         end
         S_DATA: begin
            if (accept && byte_cnt == 2'd3) begin
`ifdef CORE_BOOT_LOADER_CKSUM_EN
               state_nxt = S_CSUM;
`else
               frame_end = 1'b1;
`endif
            end
         end
`ifdef CORE_BOOT_LOADER_CKSUM_EN
         S_CSUM: begin
            if (accept) begin
               if (csum_nxt != 8'h00) begin
                  err_nxt   = ERR_CSUM;
                  state_nxt = S_CMD;
               end else begin
                  frame_end = 1'b1;
               end
            end
         end
`endif
         S_WRITE: state_nxt = S_CMD;
         default: state_nxt = S_CMD;
      endcase

      // Instruction memory may not be touched while the pipeline is live.
      if (frame_end) begin
         if (is_insn && run) begin
            err_nxt   = ERR_RUN;
            state_nxt = S_CMD;
         end else begin
            state_nxt = S_WRITE;
            load_out  = 1'b1;
         end
      end

      if (timed_out) begin
         err_nxt   = ERR_TO;
         state_nxt = S_CMD;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_cnt    <= 2'd0;
         is_insn     <= 1'b0;
         addr_sh     <= 32'd0;
         data_sh     <= 32'd0;
         timer       <= 32'd0;
         run         <= 1'b0;
         err_code    <= ERR_NONE;
         insn_addr   <= 32'd0;
         insn_din    <= 32'd0;
         data_addr   <= 32'd0;
         data_din    <= 32'd0;
         write_count <= '0;
`ifdef CORE_BOOT_LOADER_CKSUM_EN
         csum        <= 8'h00;
`endif
      end else begin
         run      <= run_nxt;
         err_code <= err_nxt;

         if (state == S_CMD && accept) begin
            is_insn  <= (in_data == CMD_INSN);
            byte_cnt <= 2'd0;
`ifdef CORE_BOOT_LOADER_CKSUM_EN
            csum     <= in_data;
`endif
         end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef CORE_BOOT_LOADER_CKSUM_EN
            csum     <= csum_nxt;
`endif
         end

         if (state == S_ADDR && accept)
            addr_sh[{byte_cnt, 3'b000} +: 8] <= in_data;
         if (state == S_DATA && accept)
            data_sh <= data_merge;

         if (state == S_CMD || accept || timed_out)
            timer <= 32'd0;
         else if (in_frame)
            timer <= timer + 32'd1;

         if (load_out) begin
            if (is_insn) begin
               insn_addr <= addr_sh;
               insn_din  <= data_merge;
            end else begin
               data_addr <= addr_sh;
               data_din  <= data_merge;
            end
         end

         if (state == S_WRITE)
            write_count <= write_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_core_boot_loader.sv
// tb/tb_core_boot_loader.sv - directed self-checking bench for core_boot_loader
// Covers the CORE_BOOT_LOADER_CKSUM_EN build when that macro is defined.
module tb_core_boot_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] insn_addr, insn_din, data_addr, data_din;
   logic        insn_we, data_we, run;
   logic [2:0]  err_code;
   logic [2:0]  write_count;

   int n_pass  = 0;
   int n_total = 0;
   logic [2:0] exp_count = 3'd0;

   core_boot_loader #(.TIMEOUT_CYCLES(16), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
      .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
      .run(run), .err_code(err_code), .write_count(write_count)
   );

   always #5 clk = ~clk;

   // Entered and left at a falling edge; in_valid is left high.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         $display("FAIL send_byte: in_ready stuck low, got %0b want 1", in_ready);
         n_total++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_write(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
      logic [7:0] s;
      s = cmd;
      send_byte(cmd);
      for (int i = 0; i < 4; i++) begin send_byte(a[8*i +: 8]); s += a[8*i +: 8]; end
      for (int i = 0; i < 4; i++) begin send_byte(d[8*i +: 8]); s += d[8*i +: 8]; end
`ifdef CORE_BOOT_LOADER_CKSUM_EN
      send_byte(8'h00 - s);
`endif
   endtask

   task automatic test_reset;
      reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      n_total++;
      if ({insn_we, data_we, run, err_code, write_count, in_ready} !== 10'd0 ||
          insn_addr !== 0 || insn_din !== 0 || data_addr !== 0 || data_din !== 0)
         $display("FAIL reset_outputs: got we=%b%b run=%b err=%0d cnt=%0d rdy=%b want all 0",
                  insn_we, data_we, run, err_code, write_count, in_ready);
      else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_insn_write;
      send_write(8'h01, 32'h0, 32'h00000013);
      in_valid = 1'b0;
      n_total++;
      if (insn_we !== 1'b1 || data_we !== 1'b0 || insn_addr !== 32'h0 || insn_din !== 32'h13)
         $display("FAIL insn_write_strobe: got we=%b/%b addr=%h din=%h want 1/0 0 00000013",
                  insn_we, data_we, insn_addr, insn_din);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL ready_in_write: got %b want 0", in_ready);
      else n_pass++;
      exp_count++;
      @(negedge clk);
      n_total++;
      if (insn_we !== 1'b0 || write_count !== exp_count || insn_din !== 32'h13 || in_ready !== 1'b1)
         $display("FAIL insn_write_after: got we=%b cnt=%0d din=%h rdy=%b want 0 %0d 00000013 1",
                  insn_we, write_count, insn_din, in_ready, exp_count);
      else n_pass++;
   endtask

   task automatic test_run_data;
      send_byte(8'h03); in_valid = 1'b0;
      n_total++;
      if (run !== 1'b1) $display("FAIL run_cmd: got %b want 1", run);
      else n_pass++;
      send_write(8'h02, 32'h10, 32'hDEADBEEF);
      in_valid = 1'b0;
      n_total++;
      if (data_we !== 1'b1 || insn_we !== 1'b0 || data_addr !== 32'h10 ||
          data_din !== 32'hDEADBEEF || err_code !== 3'd0)
         $display("FAIL data_write_running: got we=%b/%b addr=%h din=%h err=%0d want 1/0 10 deadbeef 0",
                  data_we, insn_we, data_addr, data_din, err_code);
      else n_pass++;
      exp_count++;
      @(negedge clk);
   endtask

   task automatic test_insn_while_run;
      send_write(8'h01, 32'h40, 32'h11223344);
      in_valid = 1'b0;
      n_total++;
      if (insn_we !== 1'b0 || err_code !== 3'd2 || insn_addr !== 32'h0 || in_ready !== 1'b1)
         $display("FAIL insn_while_run: got we=%b err=%0d addr=%h rdy=%b want 0 2 0 1",
                  insn_we, err_code, insn_addr, in_ready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (write_count !== exp_count) $display("FAIL insn_while_run_cnt: got %0d want %0d", write_count, exp_count);
      else n_pass++;
      send_byte(8'h05); in_valid = 1'b0;
      n_total++;
      if (err_code !== 3'd0) $display("FAIL clear_err: got %0d want 0", err_code);
      else n_pass++;
      send_byte(8'h04); send_byte(8'h04); in_valid = 1'b0;
      n_total++;
      if (run !== 1'b0) $display("FAIL halt_twice: got %b want 0", run);
      else n_pass++;
      send_byte(8'h03); send_byte(8'h03); in_valid = 1'b0;
      n_total++;
      if (run !== 1'b1) $display("FAIL run_twice: got %b want 1", run);
      else n_pass++;
      send_byte(8'h04); in_valid = 1'b0;
   endtask

   task automatic test_bad_cmd;
      send_byte(8'h07); in_valid = 1'b0;
      n_total++;
      if (err_code !== 3'd1 || in_ready !== 1'b1)
         $display("FAIL bad_cmd: got err=%0d rdy=%b want 1 1", err_code, in_ready);
      else n_pass++;
      send_write(8'h01, 32'h4, 32'h12345678);
      in_valid = 1'b0;
      n_total++;
      if (insn_we !== 1'b1 || insn_addr !== 32'h4 || insn_din !== 32'h12345678 || err_code !== 3'd1)
         $display("FAIL write_after_bad_cmd: got we=%b addr=%h din=%h err=%0d want 1 4 12345678 1",
                  insn_we, insn_addr, insn_din, err_code);
      else n_pass++;
      exp_count++;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      send_byte(8'h05);
      send_byte(8'h01); send_byte(8'hAA);
      idle(15);
      n_total++;
      if (err_code !== 3'd0) $display("FAIL timeout_early: got %0d want 0", err_code);
      else n_pass++;
      idle(1);
      n_total++;
      if (err_code !== 3'd3) $display("FAIL timeout: got %0d want 3", err_code);
      else n_pass++;
      send_write(8'h02, 32'h20, 32'hCAFEF00D);
      in_valid = 1'b0;
      n_total++;
      if (data_we !== 1'b1 || data_addr !== 32'h20 || data_din !== 32'hCAFEF00D)
         $display("FAIL frame_after_timeout: got we=%b addr=%h din=%h want 1 20 cafef00d",
                  data_we, data_addr, data_din);
      else n_pass++;
      exp_count++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      send_write(8'h02, 32'h100, 32'hA5A5_0001);
      n_total++;
      if (data_we !== 1'b1 || data_addr !== 32'h100 || data_din !== 32'hA5A50001)
         $display("FAIL b2b_first: got we=%b addr=%h din=%h want 1 100 a5a50001", data_we, data_addr, data_din);
      else n_pass++;
      exp_count++;
      send_write(8'h01, 32'h104, 32'h5A5A_0002);
      in_valid = 1'b0;
      n_total++;
      if (insn_we !== 1'b1 || insn_addr !== 32'h104 || insn_din !== 32'h5A5A0002 || data_din !== 32'hA5A50001)
         $display("FAIL b2b_second: got we=%b addr=%h din=%h ddin=%h want 1 104 5a5a0002 a5a50001",
                  insn_we, insn_addr, insn_din, data_din);
      else n_pass++;
      exp_count++;
      @(negedge clk);
      n_total++;
      if (write_count !== exp_count) $display("FAIL b2b_count: got %0d want %0d", write_count, exp_count);
      else n_pass++;
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 8 && exp_count != 3'd7; i++) begin
         send_write(8'h02, 32'h200, i);
         exp_count++;
      end
      idle(1);
      n_total++;
      if (write_count !== 3'd7) $display("FAIL wrap_pre: got %0d want 7", write_count);
      else n_pass++;
      send_write(8'h02, 32'h204, 32'h0);
      idle(1);
      exp_count++;
      n_total++;
      if (write_count !== 3'd0 || err_code !== 3'd3)
         $display("FAIL wrap: got cnt=%0d err=%0d want 0 3", write_count, err_code);
      else n_pass++;
   endtask

`ifdef CORE_BOOT_LOADER_CKSUM_EN
   task automatic test_cksum;
      // 02 | 08 00 00 00 | 01 00 00 00 sums to 0x0B; correct tail is 0xF5
      logic [7:0] frame [9];
      frame = '{8'h02, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 9; i++) send_byte(frame[i]);
      send_byte(8'hF6);
      in_valid = 1'b0;
      n_total++;
      if (data_we !== 1'b0 || err_code !== 3'd4)
         $display("FAIL cksum_bad: got we=%b err=%0d want 0 4", data_we, err_code);
      else n_pass++;
      idle(1);
      for (int i = 0; i < 9; i++) send_byte(frame[i]);
      send_byte(8'hF5);
      in_valid = 1'b0;
      n_total++;
      if (data_we !== 1'b1 || data_addr !== 32'h8 || data_din !== 32'h1)
         $display("FAIL cksum_good: got we=%b addr=%h din=%h want 1 8 1", data_we, data_addr, data_din);
      else n_pass++;
      exp_count++;
      idle(1);
   endtask
`endif

   task automatic test_reset_mid_frame;
      send_byte(8'h03);
      send_byte(8'h02);
      for (int i = 0; i < 4; i++) send_byte(8'h30);
      send_byte(8'h77); send_byte(8'h66);
      in_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      n_total++;
      if (run !== 1'b0 || data_we !== 1'b0 || write_count !== 3'd0 || in_ready !== 1'b0)
         $display("FAIL reset_mid: got run=%b we=%b cnt=%0d rdy=%b want 0 0 0 0",
                  run, data_we, write_count, in_ready);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      exp_count = 3'd0;
      @(negedge clk);
      send_write(8'h02, 32'h44, 32'h89ABCDEF);
      in_valid = 1'b0;
      n_total++;
      if (data_we !== 1'b1 || data_addr !== 32'h44 || data_din !== 32'h89ABCDEF)
         $display("FAIL after_reset_frame: got we=%b addr=%h din=%h want 1 44 89abcdef",
                  data_we, data_addr, data_din);
      else n_pass++;
      exp_count++;
      @(negedge clk);
      n_total++;
      if (write_count !== exp_count) $display("FAIL after_reset_cnt: got %0d want %0d", write_count, exp_count);
      else n_pass++;
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_insn_write;
      test_run_data;
      test_insn_while_run;
      test_bad_cmd;
      test_timeout;
      test_back_to_back;
      test_wrap;
`ifdef CORE_BOOT_LOADER_CKSUM_EN
      test_cksum;
`endif
      test_reset_mid_frame;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

endmodule
